// File: rtl/mul_simple.sv
// Unsigned multiplier built as a shift-and-add array with ripple-carry accumulation,
// exposing the combinational product and a one-cycle registered copy.
module mul_simple #(
    parameter int DATA_1_WIDTH = 8,
    parameter int DATA_2_WIDTH = 8,
    parameter int RES_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_1_WIDTH-1:0] data_1,
    input  logic [DATA_2_WIDTH-1:0] data_2,
    output logic [RES_WIDTH-1:0]    result,
    output logic [RES_WIDTH-1:0]    result_q
);

    localparam int FULL_W = DATA_1_WIDTH + DATA_2_WIDTH;

    // Bit-serial full-adder chain; the carry out of the MSB can never be set
    // because every partial sum fits in FULL_W bits.
    function automatic logic [FULL_W-1:0] ripple_add(input logic [FULL_W-1:0] a,
                                                     input logic [FULL_W-1:0] b);
        logic [FULL_W-1:0] s;
        logic              c;
        c = 1'b0;
        for (int k = 0; k < FULL_W; k++) begin
            s[k] = a[k] ^ b[k] ^ c;
            c    = (a[k] & b[k]) | (c & (a[k] ^ b[k]));
        end
        return s;
    endfunction

    // Zero-extends or truncates the full product to the result width.
    function automatic logic [RES_WIDTH-1:0] fit_res(input logic [FULL_W-1:0] p);
        logic [FULL_W+RES_WIDTH-1:0] ext;
        ext = {{RES_WIDTH{1'b0}}, p};
        return ext[RES_WIDTH-1:0];
    endfunction

    logic [FULL_W-1:0] data_1_ext;
    logic [FULL_W-1:0] product;
    logic [RES_WIDTH-1:0] result_d;

    assign data_1_ext = {{DATA_2_WIDTH{1'b0}}, data_1};

    for (genvar i = 0; i < DATA_2_WIDTH; i++) begin : g_row
        logic [FULL_W-1:0] pp;
        logic [FULL_W-1:0] sum;

        assign pp = (data_1_ext & {FULL_W{data_2[i]}}) << i;

        if (i == 0) begin : g_first
            assign sum = pp;
        end else begin : g_rest
            assign sum = ripple_add(g_row[i-1].sum, pp);
        end
    end

    assign product  = g_row[DATA_2_WIDTH-1].sum;
    assign result_d = fit_res(product);
    assign result   = result_d;

    // Registered output stage
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
        end else begin
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_mul_simple.sv
// Scoreboard bench for mul_simple: an 8x4->16 instance and an 8x8->8 truncating instance
// driven in lockstep; expectations are queued by the stimulus and checked by a monitor.
module tb_mul_simple;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  a_d1;
    logic [3:0]  a_d2;
    logic [15:0] a_res, a_res_q;
    logic [7:0]  b_d1, b_d2;
    logic [7:0]  b_res, b_res_q;

    always #5 clk = ~clk;

    mul_simple #(.DATA_1_WIDTH(8), .DATA_2_WIDTH(4), .RES_WIDTH(16)) u_dut_a (
        .clk(clk), .rst(rst), .data_1(a_d1), .data_2(a_d2),
        .result(a_res), .result_q(a_res_q)
    );

    mul_simple #(.DATA_1_WIDTH(8), .DATA_2_WIDTH(8), .RES_WIDTH(8)) u_dut_b (
        .clk(clk), .rst(rst), .data_1(b_d1), .data_2(b_d2),
        .result(b_res), .result_q(b_res_q)
    );

    typedef struct {
        logic [15:0] a_res;
        logic [15:0] a_q;
        logic [7:0]  b_res;
        logic [7:0]  b_q;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] a_q_model;
    logic [7:0]  b_q_model;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%04h, expected 0x%04h at %0t", name, act, req, $time);
    endtask

    // Drive both instances for one cycle and queue what the monitor should see at the
    // following falling edge: the new products, and the registered values loaded on the
    // edge just passed.
    task automatic step(input logic r, input logic [7:0] x1, input logic [3:0] y1,
                        input logic [15:0] e1, input logic [7:0] x2, input logic [7:0] y2,
                        input logic [7:0] e2);
        exp_t e;
        rst  = r;
        a_d1 = x1; a_d2 = y1;
        b_d1 = x2; b_d2 = y2;
        e.a_res = e1;
        e.a_q   = a_q_model;
        e.b_res = e2;
        e.b_q   = b_q_model;
        sb_q.push_back(e);
        a_q_model = r ? 16'd0 : e1;
        b_q_model = r ? 8'd0  : e2;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check16("a_result",   a_res,          e.a_res);
            check16("a_result_q", a_res_q,        e.a_q);
            check16("b_result",   {8'd0, b_res},  {8'd0, e.b_res});
            check16("b_result_q", {8'd0, b_res_q}, {8'd0, e.b_q});
        end
    end

    initial begin
        logic [7:0]  r1, r2, r3;
        logic [3:0]  r4;
        logic [15:0] pa, pb;

        rst = 1'b1;
        a_d1 = '0; a_d2 = '0; b_d1 = '0; b_d2 = '0;
        @(posedge clk);
        #1;
        a_q_model = 16'd0;
        b_q_model = 8'd0;

        // Reset held: registers stay at zero while products track inputs
        step(1'b1,   8'd0,  4'd0,  16'd0,     8'd0,   8'd0,   8'd0);
        step(1'b0, 8'd255, 4'd15,  16'd3825,  8'd16,  8'd17,  8'h10);
        step(1'b0,   8'd0,  4'd9,  16'd0,     8'd255, 8'd255, 8'h01);
        step(1'b0, 8'd173,  4'd1,  16'd173,   8'd173, 8'd1,   8'd173);
        step(1'b0, 8'd200, 4'd10,  16'd2000,  8'd15,  8'd15,  8'd225);
        step(1'b0,   8'd1,  4'd8,  16'd8,     8'd128, 8'd2,   8'd0);
        // Reset mid-stream, then resume
        step(1'b1, 8'd255, 4'd15,  16'd3825,  8'd3,   8'd5,   8'd15);
        step(1'b0,   8'd9,  4'd7,  16'd63,    8'd10,  8'd20,  8'd200);
        step(1'b0,  8'd17,  4'd3,  16'd51,    8'd255, 8'd1,   8'd255);
        step(1'b0, 8'd128,  4'd2,  16'd256,   8'd0,   8'd77,  8'd0);

        for (int i = 0; i < 2000; i++) begin
            r1 = 8'($random);
            r4 = 4'($random);
            r2 = 8'($random);
            r3 = 8'($random);
            pa = 16'(r1) * 16'(r4);
            pb = 16'(r2) * 16'(r3);
            step(1'b0, r1, r4, pa, r2, r3, pb[7:0]);
        end

        // Let the monitor drain the last entry, bounded
        for (int i = 0; i < 4 && sb_q.size() != 0; i++) @(negedge clk);
        #1;
        n_checks++;
        if (sb_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d entries left, expected 0", sb_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mul_simple.md
MUL_SIMPLE -- requirements
Module: mul_simple

Interface
REQ-001 Parameter DATA_1_WIDTH, default 8: bit width of operand data_1, legal range 1..32.
REQ-002 Parameter DATA_2_WIDTH, default 8: bit width of operand data_2, legal range 1..32.
REQ-003 Parameter RES_WIDTH, default 16: bit width of result and result_q, legal range 1..64.
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge only.
REQ-005 Port rst, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 Port data_1, input, DATA_1_WIDTH bits: unsigned multiplicand.
REQ-007 Port data_2, input, DATA_2_WIDTH bits: unsigned multiplier.
REQ-008 Port result, output, RES_WIDTH bits: combinational unsigned product of data_1 and data_2.
REQ-009 Port result_q, output, RES_WIDTH bits: registered copy of result.
REQ-010 Port declaration order SHALL be clk, rst, data_1, data_2, result, result_q.

Function
REQ-011 Operands are unsigned; no sign extension SHALL occur anywhere.
REQ-012 The full product width is DATA_1_WIDTH + DATA_2_WIDTH bits.
REQ-013 result SHALL equal (data_1 * data_2) mod 2^RES_WIDTH; when RES_WIDTH exceeds the full product width, the upper bits SHALL be zero.
REQ-014 result SHALL be purely combinational; a change on data_1 or data_2 SHALL reach result within the same simulation timestep, with zero clock latency.
REQ-015 result SHALL NOT depend on clk or rst.
REQ-016 The product SHALL be formed as a generate-built shift-and-add array: one partial product per data_2 bit, equal to data_1 ANDed with that bit and shifted left by the bit index.
REQ-017 Partial products SHALL be summed by an explicit ripple-carry adder chain at the full product width; the behavioural * operator SHALL NOT be used.
REQ-018 On every rising clk edge with rst=0, result_q SHALL load the value of result; latency is exactly 1 cycle.
REQ-019 No handshake applies; inputs are accepted every cycle and the block has no busy or stall condition.
REQ-020 Maximum operands (all ones) SHALL produce no overflow at the full product width; any truncation follows REQ-013 only.
REQ-021 X or Z on any operand bit MAY propagate to result; no masking is required.

Reset
REQ-022 On a rising clk edge with rst=1, result_q SHALL become 0.
REQ-023 rst SHALL take priority over the load in REQ-018.
REQ-024 A reset asserted during operation SHALL clear result_q on that edge only; result SHALL keep tracking its inputs throughout.
REQ-025 The first rising edge after rst deasserts SHALL load result into result_q normally.

Verification
REQ-026 With DATA_1_WIDTH=8, DATA_2_WIDTH=4, RES_WIDTH=16: data_1=255, data_2=15 -> result=3825 (0x0EF1) immediately, and result_q=3825 after one clk edge.
REQ-027 Zero and identity: data_1=0, data_2=9 -> result=0; data_1=173, data_2=1 -> result=173.
REQ-028 Random sweep: at least 2000 cycles of $random operands, changed once per 10-time-unit clock period; a reference model zero-extends both operands to RES_WIDTH and multiplies; every result mismatch is reported and fails the test.
REQ-029 Truncation: DATA_1_WIDTH=8, DATA_2_WIDTH=8, RES_WIDTH=8; data_1=16, data_2=17 -> result=0x10 (low 8 bits of 272).
REQ-030 Reset mid-stream: result_q nonzero, rst=1 for one edge -> result_q=0 after that edge while result still shows the current product; rst=0 -> result_q equals the product on the next edge.
